// File: rtl/vga_pixel_serializer.sv
`timescale 1ns/1ps
// Serializes 32-bit pixel words into one BPP-wide pixel per clock during the VGA active region.
// A hold register plus the shift register give two words of buffering; refills are requested via word_req.
module vga_pixel_serializer #(
    parameter int BPP = 8
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [1:0]     VGA_state,
    input  logic [31:0]    data_to_VGA,
    input  logic           word_valid,
    output logic           word_req,
    output logic [BPP-1:0] pixel_out,
    output logic           pixel_valid,
    output logic           underrun
);

    localparam int PPW   = 32 / BPP;
    localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;

    if (BPP != 1 && BPP != 2 && BPP != 4 && BPP != 8 && BPP != 16 && BPP != 32) begin : g_bad_bpp
        $error("vga_pixel_serializer: BPP must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        ST_SYNC       = 2'd0,
        ST_BACKPORCH  = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_FRONTPORCH = 2'd3
    } vga_state_t;

    vga_state_t vstate;
    assign vstate = vga_state_t'(VGA_state);

    logic [31:0]      shift_reg, shift_reg_n;
    logic [31:0]      hold_reg, hold_reg_n;
    logic             shift_full, shift_full_n;
    logic             hold_full, hold_full_n;
    logic [CNT_W-1:0] pix_cnt, pix_cnt_n;
    logic [BPP-1:0]   pixel_out_n;
    logic             pixel_valid_n;
    logic             underrun_n;
    logic             was_active;

    logic is_active, flush, accept, shifting, last_pix, transfer;

    assign is_active = (vstate == ST_ACTIVE);
    // First front-porch cycle after the active region drops any partial word.
    assign flush     = (vstate == ST_FRONTPORCH) && was_active;
    assign accept    = word_valid && word_req;
    assign shifting  = is_active && shift_full;
    assign last_pix  = shifting && (pix_cnt == CNT_W'(PPW - 1));
    assign transfer  = hold_full && (!shift_full || last_pix) && !flush;

    // NOTE: combinational next-state logic uses blocking assignments and gives every
    // output a default first, so no path leaves a signal unassigned (no latch).
    always_comb begin
        shift_reg_n   = shift_reg;
        shift_full_n  = shift_full;
        pix_cnt_n     = pix_cnt;
        hold_reg_n    = hold_reg;
        pixel_out_n   = '0;
        pixel_valid_n = 1'b0;
        underrun_n    = underrun;

        if (shifting) begin
            pixel_out_n   = shift_reg[31 -: BPP];
            pixel_valid_n = 1'b1;
            shift_reg_n   = shift_reg << BPP;
            pix_cnt_n     = pix_cnt + CNT_W'(1);
            if (last_pix) begin
                pix_cnt_n    = '0;
                shift_full_n = 1'b0;
            end
        end else if (is_active && !hold_full) begin
            underrun_n = 1'b1;
        end

        if (transfer) begin
            shift_reg_n  = hold_reg;
            shift_full_n = 1'b1;
            pix_cnt_n    = '0;
        end

        if (flush) begin
            shift_reg_n  = '0;
            shift_full_n = 1'b0;
            pix_cnt_n    = '0;
            hold_reg_n   = '0;
        end

        // A word arriving on the flush cycle belongs to the next line and is kept.
        if (accept) begin
            hold_reg_n = data_to_VGA;
        end
        hold_full_n = accept || (hold_full && !transfer && !flush);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous,
    // so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            shift_reg   <= '0;
            hold_reg    <= '0;
            shift_full  <= 1'b0;
            hold_full   <= 1'b0;
            pix_cnt     <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            word_req    <= 1'b0;
            underrun    <= 1'b0;
            was_active  <= 1'b0;
        end else begin
            shift_reg   <= shift_reg_n;
            hold_reg    <= hold_reg_n;
            shift_full  <= shift_full_n;
            hold_full   <= hold_full_n;
            pix_cnt     <= pix_cnt_n;
            pixel_out   <= pixel_out_n;
            pixel_valid <= pixel_valid_n;
            word_req    <= !hold_full_n;
            underrun    <= underrun_n;
            was_active  <= is_active;
        end
    end

endmodule
